// File: rtl/if_stage_pkg.sv
// Shared encodings for the instruction-fetch stage: FSM states and reset vector.
package if_stage_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h0000_3000;
  localparam logic [31:0] PcStep         = 32'd4;

  // FETCH: request outstanding; FULL: skid entry occupied, no request;
  // DROP: request outstanding whose data is stale after a redirect.
  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StFull  = 2'd1,
    StDrop  = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID output register: holds the live instruction and its PC for decode.
module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] ins_i,
  input  logic [31:0] pc_i,
  output logic        valid_o,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pc_q, pc_d;

  // Clear (flush/consume) wins over load; otherwise hold.
  always_comb begin
    valid_d = valid_q;
    ins_d   = ins_q;
    pc_d    = pc_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ins_d   = ins_i;
      pc_d    = pc_i;
    end
  end

  // Register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ins_q   <= 32'd0;
      pc_q    <= 32'd0;
    end else begin
      valid_q <= valid_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign ins_o   = ins_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding request, one-entry skid buffer,
// redirect handling with stale-response dropping.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  if_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] buf_ins_q, buf_ins_d;
  logic [31:0] buf_pc_q, buf_pc_d;

  logic        out_load, out_clear;
  logic [31:0] out_ins, out_pc;

  // Next-state, fetch PC and output-register control; redirect beats ack and stall.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    buf_ins_d  = buf_ins_q;
    buf_pc_d   = buf_pc_q;
    out_load   = 1'b0;
    out_clear  = 1'b0;
    out_ins    = imem_rdata;
    out_pc     = fetch_pc_q;
    case (state_q)
      StFetch: begin
        if (redirect) begin
          out_clear = 1'b1;
          if (imem_ack) begin
            fetch_pc_d = redirect_pc;
          end else begin
            pend_pc_d = redirect_pc;
            state_d   = StDrop;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + PcStep;
          if (!if_valid || !stall) begin
            out_load = 1'b1;
          end else begin
            buf_ins_d = imem_rdata;
            buf_pc_d  = fetch_pc_q;
            state_d   = StFull;
          end
        end else if (!stall) begin
          out_clear = 1'b1;
        end
      end
      StFull: begin
        if (redirect) begin
          out_clear  = 1'b1;
          fetch_pc_d = redirect_pc;
          state_d    = StFetch;
        end else if (!stall) begin
          out_load = 1'b1;
          out_ins  = buf_ins_q;
          out_pc   = buf_pc_q;
          state_d  = StFetch;
        end
      end
      StDrop: begin
        out_clear = 1'b1;
        if (redirect) begin
          pend_pc_d = redirect_pc;
        end
        if (imem_ack) begin
          // Newest redirect wins even when it lands on the ack cycle.
          fetch_pc_d = redirect ? redirect_pc : pend_pc_q;
          state_d    = StFetch;
        end
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      fetch_pc_q <= RESET_PC;
      pend_pc_q  <= 32'd0;
      buf_ins_q  <= 32'd0;
      buf_pc_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      buf_ins_q  <= buf_ins_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  assign imem_req  = (state_q != StFull);
  // In DROP fetch_pc_q still holds the address issued before the redirect.
  assign imem_addr = fetch_pc_q;
  assign if_pc4    = if_pc + PcStep;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (out_load),
    .clear_i (out_clear),
    .ins_i   (out_ins),
    .pc_i    (out_pc),
    .valid_o (if_valid),
    .ins_o   (if_ins),
    .pc_o    (if_pc)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with hand-computed expectations.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  int n_cmp = 0;
  int n_err = 0;

  if_stage #(
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ins      (if_ins),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs, then advance one rising edge and settle.
  task automatic cyc(input logic r, input logic st, input logic ack, input logic [31:0] rd,
                     input logic rdr, input logic [31:0] rpc);
    rst         = r;
    stall       = st;
    imem_ack    = ack;
    imem_rdata  = rd;
    redirect    = rdr;
    redirect_pc = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    redirect = 1'b0; redirect_pc = 32'd0;
    #1;
  endtask

  initial begin
    idle_inputs();
    // Reset, with an ack during reset that must be ignored.
    cyc(1, 0, 0, 32'd0, 0, 32'd0);
    cyc(1, 0, 1, 32'hBAD0_0001, 0, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_ins", if_ins, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    idle_inputs();
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0000_3000);

    // Single-cycle ack stream, one instruction per cycle.
    cyc(0, 0, 1, 32'h1111_0000, 0, 32'd0);
    check("s0_valid", {31'd0, if_valid}, 32'd1);
    check("s0_pc", if_pc, 32'h0000_3000);
    check("s0_ins", if_ins, 32'h1111_0000);
    check("s0_pc4", if_pc4, 32'h0000_3004);
    cyc(0, 0, 1, 32'h1111_0004, 0, 32'd0);
    check("s1_valid", {31'd0, if_valid}, 32'd1);
    check("s1_pc", if_pc, 32'h0000_3004);
    cyc(0, 0, 1, 32'h1111_0008, 0, 32'd0);
    check("s2_valid", {31'd0, if_valid}, 32'd1);
    check("s2_pc", if_pc, 32'h0000_3008);
    check("s2_ins", if_ins, 32'h1111_0008);
    check("s2_addr", imem_addr, 32'h0000_300C);
    // No ack: stall holds, no stall consumes.
    cyc(0, 1, 0, 32'd0, 0, 32'd0);
    check("hold_valid", {31'd0, if_valid}, 32'd1);
    check("hold_pc", if_pc, 32'h0000_3008);
    cyc(0, 0, 0, 32'd0, 0, 32'd0);
    check("consume_valid", {31'd0, if_valid}, 32'd0);

    // Stall with ack goes to FULL, release drains the buffer.
    cyc(1, 0, 0, 32'd0, 0, 32'd0);
    cyc(0, 0, 1, 32'h2222_0000, 0, 32'd0);
    check("f0_pc", if_pc, 32'h0000_3000);
    cyc(0, 1, 1, 32'h2222_0004, 0, 32'd0);
    check("full_req", {31'd0, imem_req}, 32'd0);
    check("full_pc", if_pc, 32'h0000_3000);
    check("full_ins", if_ins, 32'h2222_0000);
    cyc(0, 1, 0, 32'd0, 0, 32'd0);
    check("full2_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 0, 32'd0, 0, 32'd0);
    check("drain_valid", {31'd0, if_valid}, 32'd1);
    check("drain_pc", if_pc, 32'h0000_3004);
    check("drain_ins", if_ins, 32'h2222_0004);
    check("drain_req", {31'd0, imem_req}, 32'd1);
    check("drain_addr", imem_addr, 32'h0000_3008);

    // Redirect without ack: DROP until the late ack, then refetch 0x4000.
    cyc(0, 1, 0, 32'd0, 1, 32'h0000_4000);
    check("drop_valid", {31'd0, if_valid}, 32'd0);
    check("drop_req", {31'd0, imem_req}, 32'd1);
    check("drop_addr", imem_addr, 32'h0000_3008);
    cyc(0, 0, 0, 32'd0, 0, 32'd0);
    cyc(0, 0, 0, 32'd0, 0, 32'd0);
    check("drop2_valid", {31'd0, if_valid}, 32'd0);
    check("drop2_addr", imem_addr, 32'h0000_3008);
    cyc(0, 0, 1, 32'hDEAD_0001, 0, 32'd0);
    check("drop_ack_valid", {31'd0, if_valid}, 32'd0);
    check("drop_ack_addr", imem_addr, 32'h0000_4000);

    // Redirect with ack in the same cycle.
    cyc(0, 0, 1, 32'hDEAD_0002, 1, 32'h0000_5000);
    check("rda_valid", {31'd0, if_valid}, 32'd0);
    check("rda_addr", imem_addr, 32'h0000_5000);
    check("rda_req", {31'd0, imem_req}, 32'd1);

    // Two redirects in DROP: newest wins.
    cyc(0, 0, 0, 32'd0, 1, 32'h0000_6000);
    cyc(0, 0, 0, 32'd0, 1, 32'h0000_7000);
    check("dd_addr", imem_addr, 32'h0000_5000);
    cyc(0, 0, 1, 32'hDEAD_0003, 0, 32'd0);
    check("dd_ack_addr", imem_addr, 32'h0000_7000);
    check("dd_ack_valid", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 1, 32'h7777_0000, 0, 32'd0);
    check("dd_pc", if_pc, 32'h0000_7000);
    check("dd_ins", if_ins, 32'h7777_0000);
    check("dd_pc4", if_pc4, 32'h0000_7004);

    // Reset while FULL with stall and an ack present.
    cyc(0, 1, 1, 32'h7777_0004, 0, 32'd0);
    check("pre_rst_req", {31'd0, imem_req}, 32'd0);
    cyc(1, 1, 1, 32'hBAD0_0002, 0, 32'd0);
    check("rf_valid", {31'd0, if_valid}, 32'd0);
    check("rf_addr", imem_addr, 32'h0000_3000);
    check("rf_req", {31'd0, imem_req}, 32'd1);
    check("rf_ins", if_ins, 32'd0);

    // PC wrap at the top of the address space.
    cyc(0, 0, 1, 32'hDEAD_0004, 1, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 1, 32'h9999_0000, 0, 32'd0);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_pc4, 32'h0000_0000);
    check("wrap_next", imem_addr, 32'h0000_0000);

    // Redirect out of FULL discards the buffer.
    cyc(0, 1, 1, 32'h9999_0004, 0, 32'd0);
    check("full_b_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 1, 0, 32'd0, 1, 32'h0000_8000);
    check("fr_valid", {31'd0, if_valid}, 32'd0);
    check("fr_req", {31'd0, imem_req}, 32'd1);
    check("fr_addr", imem_addr, 32'h0000_8000);
    cyc(0, 0, 1, 32'h8888_0000, 0, 32'd0);
    check("fr_pc", if_pc, 32'h0000_8000);
    check("fr_ins", if_ins, 32'h8888_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
